// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// Holds the FSM state enum, nibble width and the index-width helper.
package adder_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Index register width; a single-nibble build still needs one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/adder_seq_checker.sv
// Reference compare of the external nibble adder with a sticky error flag.
// Only instantiated when ADDER_SELF_CHECK_EN is defined.
module adder_seq_checker
    import adder_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                active,
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    input  logic [NIBBLE_W-1:0] sum,
    input  logic                cout,
    output logic                err
);

    logic [NIBBLE_W:0] exp_res;
    logic              err_d;
    logic              err_q;

    always_comb begin
        exp_res = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
        err_d   = err_q;
        if (active && ({cout, sum} != exp_res)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide adder built by feeding an external 4-bit adder one nibble per cycle, LSB first.
// Optional ADDER_SELF_CHECK_EN adds a nibble reference check and a sticky err port.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [W-1:0]        req_a,
    input  logic [W-1:0]        req_b,
    input  logic                req_cin,
    output logic [NIBBLE_W-1:0] add_a,
    output logic [NIBBLE_W-1:0] add_b,
    output logic                add_cin,
    input  logic [NIBBLE_W-1:0] add_sum,
    input  logic                add_cout,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [W-1:0]        rsp_sum,
    output logic                rsp_cout
`ifdef ADDER_SELF_CHECK_EN
    ,
    output logic                err
`endif
);

    localparam int            IW       = idx_width(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  op_a_q, op_a_d;
    logic [W-1:0]  op_b_q, op_b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          run;

    assign run = (state_q == RUN);

    // Nibble select for the adder; forced to zero outside RUN.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (run) begin
            add_cin = carry_q;
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx_q == IW'(i)) begin
                    add_a = op_a_q[i*NIBBLE_W +: NIBBLE_W];
                    add_b = op_b_q[i*NIBBLE_W +: NIBBLE_W];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_a_d      = req_a;
                    op_b_d      = req_b;
                    carry_d     = req_cin;
                    idx_d       = '0;
                    sum_d       = '0;
                    req_ready_d = 1'b0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) begin
                        sum_d[i*NIBBLE_W +: NIBBLE_W] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry_q;

`ifdef ADDER_SELF_CHECK_EN
    adder_seq_checker u_checker (
        .clk    (clk),
        .rst    (rst),
        .active (run),
        .a      (add_a),
        .b      (add_b),
        .cin    (add_cin),
        .sum    (add_sum),
        .cout   (add_cout),
        .err    (err)
    );
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: 16-bit and 4-bit instances, each wired to a 4-bit adder model.
// Define ADDER_SELF_CHECK_EN to also exercise the err port with an injected adder fault.
module tb_adder_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 16-bit instance and its adder (bit0 of the sum can be forced low)
    logic        req_valid4 = 1'b0;
    logic        req_ready4;
    logic [15:0] req_a4 = '0;
    logic [15:0] req_b4 = '0;
    logic        req_cin4 = 1'b0;
    logic [3:0]  add_a4, add_b4, add_sum4;
    logic        add_cin4, add_cout4;
    logic        rsp_valid4;
    logic        rsp_ready4 = 1'b0;
    logic [15:0] rsp_sum4;
    logic        rsp_cout4;
    logic        fault_bit0 = 1'b0;
    logic [4:0]  add_res4;

    assign add_res4  = {1'b0, add_a4} + {1'b0, add_b4} + {4'b0, add_cin4};
    assign add_sum4  = {add_res4[3:1], add_res4[0] & ~fault_bit0};
    assign add_cout4 = add_res4[4];

    // 4-bit instance and its fault-free adder
    logic       req_valid1 = 1'b0;
    logic       req_ready1;
    logic [3:0] req_a1 = '0;
    logic [3:0] req_b1 = '0;
    logic       req_cin1 = 1'b0;
    logic [3:0] add_a1, add_b1, add_sum1;
    logic       add_cin1, add_cout1;
    logic       rsp_valid1;
    logic       rsp_ready1 = 1'b0;
    logic [3:0] rsp_sum1;
    logic       rsp_cout1;

    assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {4'b0, add_cin1};

`ifdef ADDER_SELF_CHECK_EN
    logic err4, err1;
`endif

    adder_seq_ctrl #(.NIBBLES(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid4),
        .req_ready (req_ready4),
        .req_a     (req_a4),
        .req_b     (req_b4),
        .req_cin   (req_cin4),
        .add_a     (add_a4),
        .add_b     (add_b4),
        .add_cin   (add_cin4),
        .add_sum   (add_sum4),
        .add_cout  (add_cout4),
        .rsp_valid (rsp_valid4),
        .rsp_ready (rsp_ready4),
        .rsp_sum   (rsp_sum4),
        .rsp_cout  (rsp_cout4)
`ifdef ADDER_SELF_CHECK_EN
        ,
        .err       (err4)
`endif
    );

    adder_seq_ctrl #(.NIBBLES(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid1),
        .req_ready (req_ready1),
        .req_a     (req_a1),
        .req_b     (req_b1),
        .req_cin   (req_cin1),
        .add_a     (add_a1),
        .add_b     (add_b1),
        .add_cin   (add_cin1),
        .add_sum   (add_sum1),
        .add_cout  (add_cout1),
        .rsp_valid (rsp_valid1),
        .rsp_ready (rsp_ready1),
        .rsp_sum   (rsp_sum1),
        .rsp_cout  (rsp_cout1)
`ifdef ADDER_SELF_CHECK_EN
        ,
        .err       (err1)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: the response is the plain sum of the request.
    function automatic logic [16:0] model4(input logic [15:0] a, input logic [15:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {16'b0, c};
    endfunction

    function automatic logic [4:0] model1(input logic [3:0] a, input logic [3:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {4'b0, c};
    endfunction

    // Scoreboards: head entry is what the current response must carry.
    logic [16:0] exp_q4[$];
    logic [4:0]  exp_q1[$];
    int          rsp_cnt1 = 0;

    always @(negedge clk) begin
        if (!rst && rsp_valid4) begin
            if (exp_q4.size() == 0) check("rsp4_unexpected", 32'(rsp_valid4), 32'(0));
            else check("rsp4_sum", 32'({rsp_cout4, rsp_sum4}), 32'(exp_q4[0]));
        end
        if (!rst && rsp_valid1) begin
            if (exp_q1.size() == 0) check("rsp1_unexpected", 32'(rsp_valid1), 32'(0));
            else check("rsp1_sum", 32'({rsp_cout1, rsp_sum1}), 32'(exp_q1[0]));
        end
    end

    always @(posedge clk) begin
        if (!rst && rsp_valid4 && rsp_ready4 && exp_q4.size() > 0) void'(exp_q4.pop_front());
        if (!rst && rsp_valid1 && rsp_ready1 && exp_q1.size() > 0) begin
            void'(exp_q1.pop_front());
            rsp_cnt1++;
        end
    end

    // Called at a negedge; returns at the negedge rsp_valid4 is first seen,
    // with lat = cycles counted from the accept cycle.
    task automatic send4(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [16:0] exp, output int lat);
        int t = 0;
        while (!req_ready4 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_ready4_wait", 32'(req_ready4), 32'(1));
        exp_q4.push_back(exp);
        req_a4     = a;
        req_b4     = b;
        req_cin4   = c;
        req_valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid4 = 1'b0;
        lat = 1;
        while (!rsp_valid4 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic recv4(input int hold, output logic [16:0] got);
        logic [16:0] first;
        first = {rsp_cout4, rsp_sum4};
        rsp_ready4 = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_stable", 32'({rsp_cout4, rsp_sum4}), 32'(first));
            check("hold_valid", 32'(rsp_valid4), 32'(1));
            check("hold_req_ready", 32'(req_ready4), 32'(0));
        end
        got = first;
        rsp_ready4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready4 = 1'b0;
        check("post_req_ready", 32'(req_ready4), 32'(1));
        check("post_rsp_valid", 32'(rsp_valid4), 32'(0));
    endtask

    task automatic xact1(input logic [3:0] a, input logic [3:0] b, input logic c);
        int lat;
        int t = 0;
        while (!req_ready1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        exp_q1.push_back(model1(a, b, c));
        req_a1     = a;
        req_b1     = b;
        req_cin1   = c;
        req_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid1 = 1'b0;
        lat = 1;
        while (!rsp_valid1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("lat1", 32'(lat), 32'(2));
        rsp_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready1 = 1'b0;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [16:0] got;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready4), 32'(1));
        check("rst_rsp_valid", 32'(rsp_valid4), 32'(0));
        check("rst_rsp", 32'({rsp_cout4, rsp_sum4}), 32'(0));
        check("rst_add", 32'({add_cin4, add_a4, add_b4}), 32'(0));
        check("rst_req_ready1", 32'(req_ready1), 32'(1));
        rst = 1'b0;
        @(negedge clk);

        // Basic add with latency
        send4(16'h1234, 16'h0FCD, 1'b0, model4(16'h1234, 16'h0FCD, 1'b0), lat);
        check("basic_lat", 32'(lat), 32'(5));
        recv4(0, got);
        check("basic_sum", 32'(got), 32'h0_2201);

        // Full carry ripple
        send4(16'hFFFF, 16'h0001, 1'b0, model4(16'hFFFF, 16'h0001, 1'b0), lat);
        recv4(0, got);
        check("ripple1", 32'(got), 32'h1_0000);
        send4(16'hFFFF, 16'hFFFF, 1'b1, model4(16'hFFFF, 16'hFFFF, 1'b1), lat);
        recv4(0, got);
        check("ripple2", 32'(got), 32'h1_FFFF);

        // A few more directed vectors
        send4(16'h8000, 16'h8000, 1'b0, model4(16'h8000, 16'h8000, 1'b0), lat);
        recv4(0, got);
        check("msb_carry", 32'(got), 32'h1_0000);
        send4(16'hA5A5, 16'h5A5A, 1'b1, model4(16'hA5A5, 16'h5A5A, 1'b1), lat);
        recv4(0, got);
        check("alt_bits", 32'(got), 32'h1_0000);
        send4(16'h0F0F, 16'h0101, 1'b1, model4(16'h0F0F, 16'h0101, 1'b1), lat);
        recv4(0, got);
        check("mixed", 32'(got), 32'h0_1011);

        // Backpressure: hold the response for 10 cycles
        send4(16'h1111, 16'h2222, 1'b0, model4(16'h1111, 16'h2222, 1'b0), lat);
        check("bp_lat", 32'(lat), 32'(5));
        recv4(10, got);
        check("bp_sum", 32'(got), 32'h0_3333);

        // Reset in the second RUN cycle aborts with no response
        req_a4     = 16'h00FF;
        req_b4     = 16'h0001;
        req_cin4   = 1'b0;
        req_valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_req_ready", 32'(req_ready4), 32'(1));
        check("abort_rsp_valid", 32'(rsp_valid4), 32'(0));
        check("abort_rsp", 32'({rsp_cout4, rsp_sum4}), 32'(0));
        check("abort_add", 32'({add_cin4, add_a4, add_b4}), 32'(0));
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid4), 32'(0));
        end
        send4(16'h0003, 16'h0004, 1'b0, model4(16'h0003, 16'h0004, 1'b0), lat);
        check("after_abort_lat", 32'(lat), 32'(5));
        recv4(0, got);
        check("after_abort_sum", 32'(got), 32'h0_0007);

        // Exhaustive single-nibble instance
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    xact1(4'(a), 4'(b), 1'(c));
                end
            end
        end
        check("exh_count", 32'(rsp_cnt1), 32'(512));
        check("exh_queue_empty", 32'(exp_q1.size()), 32'(0));

`ifdef ADDER_SELF_CHECK_EN
        check("err4_clean", 32'(err4), 32'(0));
        check("err1_clean", 32'(err1), 32'(0));
        // Sum bit0 stuck low: 1 + 0 comes back as 0 and err must latch
        fault_bit0 = 1'b1;
        send4(16'h0001, 16'h0000, 1'b0, 17'h0_0000, lat);
        recv4(0, got);
        fault_bit0 = 1'b0;
        check("err4_set", 32'(err4), 32'(1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("err4_held", 32'(err4), 32'(1));
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("err4_cleared", 32'(err4), 32'(0));
`endif

        check("queue4_empty", 32'(exp_q4.size()), 32'(0));
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
